// File: rtl/pio_seq_pkg.sv
// -----------------------------------------------------------------------------
// pio_seq_pkg
// Shared definitions for the PIO sample sequencer:
//   - Avalon-MM word addresses of the four slave registers
//   - bit positions inside the CTRL and STATUS words
//   - packed STATUS word layout and a helper that assembles it
// -----------------------------------------------------------------------------
package pio_seq_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_DIVIDER = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_CLEAR_BIT  = 2;

  // STATUS bit positions (count occupies [7:0])
  localparam int STATUS_EMPTY_BIT    = 8;
  localparam int STATUS_FULL_BIT     = 9;
  localparam int STATUS_OVERFLOW_BIT = 10;

  // STATUS word as seen by software
  typedef struct packed {
    logic [20:0] reserved;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [7:0]  count;
  } status_t;

  function automatic status_t pack_status(input logic [7:0] count,
                                          input logic       empty,
                                          input logic       full,
                                          input logic       overflow);
    status_t s;
    s          = '0;
    s.count    = count;
    s.empty    = empty;
    s.full     = full;
    s.overflow = overflow;
    return s;
  endfunction

endpackage

// File: rtl/pio_seq_fifo.sv
// -----------------------------------------------------------------------------
// pio_seq_fifo
// Small synchronous FIFO holding captured samples.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, wdata       write request and data (dropped when full unless a pop
//                     happens in the same cycle)
//   pop               read request (ignored when empty)
//   flush             empties the FIFO; overrides push/pop in the same cycle
//   rdata             current head (valid while not empty)
//   count/empty/full  occupancy
// Pointers are log2(DEPTH) bits and wrap naturally; the separate count
// register disambiguates full from empty.
// -----------------------------------------------------------------------------
module pio_seq_fifo
  import pio_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when paired with a pop. A pop on an empty FIFO never happens.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
  end

  // Head is read combinationally so the top can register it into readdata
  // on the same edge that performs the pop.
  assign rdata = mem[rd_ptr_reg];

endmodule

// File: rtl/pio_sample_sequencer.sv
// -----------------------------------------------------------------------------
// pio_sample_sequencer
// Captures in_port on a programmable sample-rate tick into a FIFO and exposes
// it to the CPU as a 4-word Avalon-MM slave with a level interrupt.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[1:0]        0 DATA, 1 STATUS, 2 CTRL, 3 DIVIDER
//   chipselect, read,   slave strobes (read/write ignored without chipselect)
//   write, writedata
//   readdata[31:0]      registered read data, latency 1, held between reads
//   irq                 registered: irq_en & (~empty | overflow)
//   in_port[DATA_W-1:0] sampled input
// Build option:
//   PIO_SEQ_INPUT_SYNC_EN  defined: in_port passes a 2-flop synchronizer
//                          before sampling. Undefined: sampled directly.
// -----------------------------------------------------------------------------
module pio_sample_sequencer
  import pio_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [DATA_W-1:0] in_port
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sample_value;

`ifdef PIO_SEQ_INPUT_SYNC_EN
  logic [DATA_W-1:0] sync1_reg;
  logic [DATA_W-1:0] sync2_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample_value = sync2_reg;
`else
  assign sample_value = in_port;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_en;
  logic wr_en;
  logic ctrl_wr;
  logic div_wr;
  logic data_rd;
  logic clear;

  assign rd_en   = chipselect & read;
  assign wr_en   = chipselect & write;
  assign ctrl_wr = wr_en & (address == ADDR_CTRL);
  assign div_wr  = wr_en & (address == ADDR_DIVIDER);
  assign data_rd = rd_en & (address == ADDR_DATA);
  assign clear   = ctrl_wr & writedata[CTRL_CLEAR_BIT];

  // Only a handful of writedata bits are decoded.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic             enable_reg;
  logic             irq_en_reg;
  logic [DIV_W-1:0] divider_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg  <= 1'b0;
      irq_en_reg  <= 1'b0;
      divider_reg <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_reg <= writedata[CTRL_ENABLE_BIT];
        irq_en_reg <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (div_wr) divider_reg <= writedata[DIV_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-rate divider: counts 0..DIVIDER, ticks on the terminal value.
  // Any configuration write restarts the period and suppresses the tick.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             tick;

  assign tick = enable_reg & ~ctrl_wr & ~div_wr & (div_cnt_reg == divider_reg);

  always_comb begin
    div_cnt_next = div_cnt_reg + 1'b1;
    if (!enable_reg || ctrl_wr || div_wr || tick) div_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt_reg <= '0;
    else          div_cnt_reg <= div_cnt_next;
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;

  assign pop = data_rd & ~fifo_empty;

  pio_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tick),
    .pop     (pop),
    .flush   (clear),
    .wdata   (sample_value),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Sticky overflow: a tick lost to a full FIFO. A clear in the same cycle
  // discards the sample without flagging it.
  // ---------------------------------------------------------------------------
  logic overflow_reg;
  logic overflow_next;

  always_comb begin
    overflow_next = overflow_reg;
    if (clear)                              overflow_next = 1'b0;
    else if (tick && fifo_full && !pop)     overflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_reg <= 1'b0;
    else          overflow_reg <= overflow_next;
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [7:0]  count8;
  status_t     status_word;
  logic [31:0] read_word;
  logic [31:0] readdata_reg;

  always_comb begin
    count8             = '0;
    count8[CNT_W-1:0]  = fifo_count;
  end

  assign status_word = pack_status(count8, fifo_empty, fifo_full, overflow_reg);

  always_comb begin
    read_word = '0;
    case (address)
      ADDR_DATA: begin
        if (!fifo_empty) read_word[DATA_W-1:0] = fifo_rdata;
      end
      ADDR_STATUS: read_word = status_word;
      ADDR_CTRL: begin
        read_word[CTRL_ENABLE_BIT] = enable_reg;
        read_word[CTRL_IRQ_EN_BIT] = irq_en_reg;
      end
      default: read_word[DIV_W-1:0] = divider_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata_reg <= '0;
    else if (rd_en) readdata_reg <= read_word;
  end

  assign readdata = readdata_reg;

  // ---------------------------------------------------------------------------
  // Interrupt: registered from current state, so it trails state by a cycle.
  // ---------------------------------------------------------------------------
  logic irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_reg <= 1'b0;
    else          irq_reg <= irq_en_reg & (~fifo_empty | overflow_reg);
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_pio_sample_sequencer.sv
module tb_pio_sample_sequencer;

`ifdef PIO_SEQ_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [15:0] in_port = '0;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: FIFO contents as a queue plus control state
  logic [15:0] mq[$];
  logic [31:0] exp_q[$];
  logic [15:0] m_cnt, m_div;
  logic        m_en, m_ien, m_ovf, m_irq;
  logic [15:0] d1, d2;
  int          ramp = 16;

  always #5 clk = ~clk;

  pio_sample_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_port    (in_port)
  );

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_div = 0; m_en = 0; m_ien = 0; m_ovf = 0; m_irq = 0;
    d1 = 0; d2 = 0;
  endtask

  // One clock cycle of bus activity. Called just after a falling edge; the
  // reference model advances for the coming rising edge and expected read
  // data is pushed to the scoreboard queue.
  task automatic step(input bit cs, input bit rd, input bit wr,
                      input logic [1:0] a, input logic [31:0] wd);
    logic [15:0] samp;
    logic [31:0] e;
    bit          cfgw, tick, popped;
    chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
    in_port = ramp[15:0];
    samp = (SYNC_LAT == 2) ? d2 : ramp[15:0];
    d2 = d1; d1 = ramp[15:0];
    ramp++;
    if (cs && rd) begin
      e = '0;
      case (a)
        2'd0: if (mq.size() != 0) e = {16'h0, mq[0]};
        2'd1: e = {21'h0, m_ovf, mq.size() == 8, mq.size() == 0, 8'(mq.size())};
        2'd2: e = {30'h0, m_ien, m_en};
        default: e = {16'h0, m_div};
      endcase
      exp_q.push_back(e);
    end
    m_irq = m_ien && (mq.size() != 0 || m_ovf);
    cfgw = cs && wr && (a == 2'd2 || a == 2'd3);
    tick = m_en && !cfgw && (m_cnt == m_div);
    if (!m_en || cfgw || tick) m_cnt = 0; else m_cnt = m_cnt + 1;
    popped = cs && rd && a == 2'd0 && mq.size() != 0;
    if (popped) void'(mq.pop_front());
    if (cs && wr && a == 2'd2 && wd[2]) begin
      mq.delete(); m_ovf = 0;
    end else if (tick) begin
      if (mq.size() < 8) mq.push_back(samp); else m_ovf = 1;
    end
    if (cs && wr && a == 2'd2) begin m_en = wd[0]; m_ien = wd[1]; end
    if (cs && wr && a == 2'd3) m_div = wd[15:0];
    @(posedge clk);
    @(negedge clk);
    chipselect = 0; read = 0; write = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    step(1, 0, 1, a, wd);
    $display("write addr=%0d data=0x%08h", a, wd);
  endtask

  task automatic bus_read(input logic [1:0] a);
    step(1, 1, 0, a, 32'h0);
    $display("read  addr=%0d data=0x%08h irq=%0b", a, readdata, irq);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] req [4];
    logic [31:0] e;
    req[0] = 32'h0; req[1] = 32'h100; req[2] = 32'h0; req[3] = 32'h0;
    do_reset();
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_out readdata=0x%08h irq=%b required 0/0", readdata, irq);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i));
      e = exp_q.pop_front();
      checks++;
      if (readdata !== req[i] || readdata !== e) begin
        errors++;
        $display("FAIL reset_reg%0d got=0x%08h required=0x%08h model=0x%08h", i, readdata, req[i], e);
      end
    end
  endtask

  task automatic test_ramp();
    int r0;
    logic [31:0] e;
    bus_write(2'd3, 32'd3);
    bus_write(2'd2, 32'd1);
    r0 = ramp - SYNC_LAT;
    idle(16);
    bus_write(2'd2, 32'd0);
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h004 || readdata !== e) begin
      errors++; $display("FAIL ramp_status got=0x%08h required=0x004", readdata);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd0);
      e = exp_q.pop_front();
      checks++;
      if (readdata !== 32'(r0 + 3 + 4 * i) || readdata !== e) begin
        errors++;
        $display("FAIL ramp_data%0d got=0x%08h required=0x%08h model=0x%08h", i, readdata, 32'(r0 + 3 + 4 * i), e);
      end
    end
  endtask

  task automatic test_overflow_and_full_pop(output int v0);
    int w;
    logic [31:0] e;
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd1);
    v0 = ramp - SYNC_LAT;
    idle(9);
    bus_write(2'd2, 32'd0);
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h608 || readdata !== e) begin
      errors++; $display("FAIL ovf_status got=0x%08h required=0x608", readdata);
    end
    // DATA read coinciding with a tick on a full FIFO
    bus_write(2'd2, 32'd1);
    w = ramp - SYNC_LAT;
    bus_read(2'd0);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'(v0) || readdata !== e) begin
      errors++; $display("FAIL fullpop_head got=0x%08h required=0x%08h", readdata, 32'(v0));
    end
    bus_write(2'd2, 32'd0);
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h608 || readdata !== e) begin
      errors++; $display("FAIL fullpop_status got=0x%08h required=0x608", readdata);
    end
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0);
      e = exp_q.pop_front();
      checks++;
      if (readdata !== ((i == 8) ? 32'(w) : 32'(v0 + i)) || readdata !== e) begin
        errors++;
        $display("FAIL drain%0d got=0x%08h required=0x%08h", i, readdata, (i == 8) ? 32'(w) : 32'(v0 + i));
      end
    end
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h500 || readdata !== e) begin
      errors++; $display("FAIL drained_status got=0x%08h required=0x500", readdata);
    end
  endtask

  task automatic test_irq();
    logic [31:0] e;
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'd5);
    bus_write(2'd2, 32'd3);
    idle(6);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got=%b required=0", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin errors++; $display("FAIL irq_rise got=%b required=1", irq); end
    bus_write(2'd2, 32'd2);
    bus_read(2'd0);
    void'(exp_q.pop_front());
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b required=0", irq); end
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd3);
    idle(9);
    bus_write(2'd2, 32'd2);
    idle(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_ovf got=%b required=1", irq); end
    bus_write(2'd2, 32'd6);
    idle(1);
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h100 || readdata !== e || irq !== 1'b0) begin
      errors++; $display("FAIL clear_status got=0x%08h irq=%b required=0x100 irq=0", readdata, irq);
    end
  endtask

  task automatic test_empty_read();
    logic [31:0] e;
    bus_read(2'd0);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h0 || readdata !== e) begin
      errors++; $display("FAIL empty_data got=0x%08h required=0", readdata);
    end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'h1234);
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h100 || readdata !== e) begin
      errors++; $display("FAIL empty_status got=0x%08h required=0x100", readdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd3);
    idle(3);
    bus_read(2'd0);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e || irq !== 1'b1) begin
      errors++; $display("FAIL burst_data got=0x%08h irq=%b required=0x%08h irq=1", readdata, irq, e);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_reset readdata=0x%08h irq=%b required 0/0", readdata, irq);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h100 || readdata !== e) begin
      errors++; $display("FAIL post_reset_status got=0x%08h required=0x100", readdata);
    end
    bus_read(2'd2);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== 32'h0 || readdata !== e) begin
      errors++; $display("FAIL post_reset_ctrl got=0x%08h required=0", readdata);
    end
  endtask

  initial begin
    int v0;
    test_reset();
    test_ramp();
    test_overflow_and_full_pop(v0);
    test_irq();
    test_empty_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
